// File: rtl/hh_pkg.sv
// Shared definitions for the Hodgkin-Huxley neuron array.
// Provides the Q-format defaults (FRAC, reversal potentials, conductances,
// thresholds), the sweep FSM state type, and the fixed-point helpers
// sat() and mulq() used by the update datapath.
package hh_pkg;

  localparam int unsigned HH_W       = 16;
  localparam int unsigned HH_FRAC    = 8;
  localparam int unsigned HH_NUM_CH  = 4;
  localparam int unsigned HH_REFRACT = 2;

  localparam int HH_V_REST  = -16640;
  localparam int HH_V_TH    = -14080;
  localparam int HH_V_RESET = -16640;
  localparam int HH_E_NA    = 12800;
  localparam int HH_E_K     = -19712;
  localparam int HH_E_L     = -13926;
  localparam int HH_G_NA    = 8;
  localparam int HH_G_K     = 9;
  localparam int HH_G_L     = 1;

  // Intermediate arithmetic width; wide enough that no sum or product wraps.
  localparam int unsigned WIDE = 64;
  typedef logic signed [WIDE-1:0] wide_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Clamp a wide signed value to the range of a w-bit signed number.
  function automatic wide_t sat(input wide_t x, input int unsigned w);
    wide_t hi;
    wide_t lo;
    hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    lo = -(wide_t'(1) <<< (w - 1));
    if (x > hi) begin
      return hi;
    end else if (x < lo) begin
      return lo;
    end
    return x;
  endfunction

  // Fixed-point multiply; the arithmetic shift floors toward minus infinity.
  function automatic wide_t mulq(input wide_t a, input wide_t b, input int unsigned frac);
    wide_t p;
    p = a * b;
    return p >>> frac;
  endfunction

endpackage

// File: rtl/hh_neuron_array_if.sv
// Step/result bus of the neuron array.
// master side (stimulus generator): step_valid, dt_k, current_in out;
//   step_ready, out_valid, out_ch, out_v, out_spike, step_done in.
// slave side (hh_neuron_array): the reverse.
interface hh_neuron_array_if #(
  parameter int unsigned W      = 16,
  parameter int unsigned NUM_CH = 4
);
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                     step_valid;
  logic                     step_ready;
  logic signed [W-1:0]      dt_k;
  logic [NUM_CH*W-1:0]      current_in;
  logic                     out_valid;
  logic [CH_W-1:0]          out_ch;
  logic signed [W-1:0]      out_v;
  logic                     out_spike;
  logic                     step_done;

  modport master (
    output step_valid, dt_k, current_in,
    input  step_ready, out_valid, out_ch, out_v, out_spike, step_done
  );

  modport slave (
    input  step_valid, dt_k, current_in,
    output step_ready, out_valid, out_ch, out_v, out_spike, step_done
  );
endinterface

// File: rtl/hh_update_dp.sv
// Two-stage fixed-point membrane update shared by all channels.
// Stage 1 registers the channel operands and the three ionic products;
// stage 2 sums, saturates, integrates, applies threshold/refractory and
// registers the result.
// Ports: clk, rst; in_valid/in_ch/in_v/in_refr/in_i/in_dt (operands for one
// channel); out_valid/out_ch/out_v/out_refr/out_spike (written-back result).
module hh_update_dp
  import hh_pkg::*;
#(
  parameter int unsigned W       = HH_W,
  parameter int unsigned FRAC    = HH_FRAC,
  parameter int unsigned CH_W    = 2,
  parameter int unsigned RW      = 2,
  parameter int          V_TH    = HH_V_TH,
  parameter int          V_RESET = HH_V_RESET,
  parameter int          E_NA    = HH_E_NA,
  parameter int          E_K     = HH_E_K,
  parameter int          E_L     = HH_E_L,
  parameter int          G_NA    = HH_G_NA,
  parameter int          G_K     = HH_G_K,
  parameter int          G_L     = HH_G_L,
  parameter int unsigned REFRACT = HH_REFRACT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [CH_W-1:0]     in_ch,
  input  logic signed [W-1:0] in_v,
  input  logic [RW-1:0]       in_refr,
  input  logic signed [W-1:0] in_i,
  input  logic signed [W-1:0] in_dt,
  output logic                out_valid,
  output logic [CH_W-1:0]     out_ch,
  output logic signed [W-1:0] out_v,
  output logic [RW-1:0]       out_refr,
  output logic                out_spike
);

  localparam logic signed [W-1:0] VTH_W    = W'(V_TH);
  localparam logic signed [W-1:0] VRESET_W = W'(V_RESET);

  wide_t p_na_c, p_k_c, p_l_c;

  logic                s1_valid;
  logic [CH_W-1:0]     s1_ch;
  logic signed [W-1:0] s1_v;
  logic [RW-1:0]       s1_refr;
  logic signed [W-1:0] s1_i;
  logic signed [W-1:0] s1_dt;
  wide_t               s1_p_na, s1_p_k, s1_p_l;

  wide_t               ion_c;
  logic signed [W-1:0] net_c;
  logic signed [W-1:0] v_int_c;
  logic signed [W-1:0] v_new_c;
  logic [RW-1:0]       refr_new_c;
  logic                spike_c;

  // Stage 1 products: g * (V - E) per ionic branch.
  always_comb begin
    p_na_c = mulq(wide_t'(G_NA), wide_t'(in_v) - wide_t'(E_NA), FRAC);
    p_k_c  = mulq(wide_t'(G_K),  wide_t'(in_v) - wide_t'(E_K),  FRAC);
    p_l_c  = mulq(wide_t'(G_L),  wide_t'(in_v) - wide_t'(E_L),  FRAC);
  end

  // Stage 1 register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_ch    <= '0;
      s1_v     <= '0;
      s1_refr  <= '0;
      s1_i     <= '0;
      s1_dt    <= '0;
      s1_p_na  <= '0;
      s1_p_k   <= '0;
      s1_p_l   <= '0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_ch   <= in_ch;
        s1_v    <= in_v;
        s1_refr <= in_refr;
        s1_i    <= in_i;
        s1_dt   <= in_dt;
        s1_p_na <= p_na_c;
        s1_p_k  <= p_k_c;
        s1_p_l  <= p_l_c;
      end
    end
  end

  // Stage 2: integrate, then refractory hold has priority over threshold.
  always_comb begin
    ion_c      = s1_p_na + s1_p_k + s1_p_l;
    net_c      = W'(sat(wide_t'(s1_i) - ion_c, W));
    v_int_c    = W'(sat(wide_t'(s1_v) + mulq(wide_t'(s1_dt), wide_t'(net_c), FRAC), W));
    v_new_c    = v_int_c;
    refr_new_c = '0;
    spike_c    = 1'b0;
    if (s1_refr != '0) begin
      v_new_c    = VRESET_W;
      refr_new_c = s1_refr - RW'(1);
    end else if (v_int_c >= VTH_W) begin
      v_new_c    = VRESET_W;
      refr_new_c = RW'(REFRACT);
      spike_c    = 1'b1;
    end
  end

  // Stage 2 register; data holds between results, spike is a per-result flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_v     <= '0;
      out_refr  <= '0;
      out_spike <= 1'b0;
    end else begin
      out_valid <= s1_valid;
      out_spike <= s1_valid & spike_c;
      if (s1_valid) begin
        out_ch   <= s1_ch;
        out_v    <= v_new_c;
        out_refr <= refr_new_c;
      end
    end
  end

endmodule

// File: rtl/hh_neuron_array.sv
// Array of NUM_CH linear Hodgkin-Huxley neurons sharing one update datapath.
// Each accepted step captures dt_k and current_in, sweeps every channel
// through hh_update_dp, writes the results back and pulses step_done.
// Ports: clk, rst (async, active-high); bus (hh_neuron_array_if.slave):
// step_valid/step_ready handshake, dt_k, current_in, per-channel result
// out_valid/out_ch/out_v/out_spike, and step_done.
module hh_neuron_array
  import hh_pkg::*;
#(
  parameter int unsigned W       = HH_W,
  parameter int unsigned FRAC    = HH_FRAC,
  parameter int unsigned NUM_CH  = HH_NUM_CH,
  parameter int          V_REST  = HH_V_REST,
  parameter int          V_TH    = HH_V_TH,
  parameter int          V_RESET = HH_V_RESET,
  parameter int          E_NA    = HH_E_NA,
  parameter int          E_K     = HH_E_K,
  parameter int          E_L     = HH_E_L,
  parameter int          G_NA    = HH_G_NA,
  parameter int          G_K     = HH_G_K,
  parameter int          G_L     = HH_G_L,
  parameter int unsigned REFRACT = HH_REFRACT
) (
  input  logic              clk,
  input  logic              rst,
  hh_neuron_array_if.slave  bus
);

  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned RW   = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;
  localparam logic signed [W-1:0] VREST_W = W'(V_REST);

  state_t              state_q, state_d;
  logic [CH_W-1:0]     cnt_q, cnt_d;
  logic                drain_q, drain_d;
  logic                step_ready_q;
  logic                step_done_q, done_d;
  logic                accept_c;
  logic                issue_c;

  logic signed [W-1:0] dt_q;
  logic [NUM_CH*W-1:0] cur_q;

  logic signed [W-1:0] v_mem    [NUM_CH];
  logic [RW-1:0]       refr_mem [NUM_CH];

  logic signed [W-1:0] rd_v_c;
  logic [RW-1:0]       rd_refr_c;
  logic signed [W-1:0] rd_i_c;

  logic                wb_valid;
  logic [CH_W-1:0]     wb_ch;
  logic signed [W-1:0] wb_v;
  logic [RW-1:0]       wb_refr;
  logic                wb_spike;

  // Sweep sequencer: one channel per cycle, then two cycles to empty the pipe.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    drain_d  = drain_q;
    done_d   = 1'b0;
    accept_c = 1'b0;
    issue_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.step_valid) begin
          accept_c = 1'b1;
          cnt_d    = '0;
          state_d  = SWEEP;
        end
      end
      SWEEP: begin
        issue_c = 1'b1;
        if (cnt_q == CH_W'(NUM_CH - 1)) begin
          cnt_d   = '0;
          drain_d = 1'b0;
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + CH_W'(1);
        end
      end
      DRAIN: begin
        if (drain_q) begin
          drain_d = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          drain_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer registers; step_ready mirrors the next state so it is a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      drain_q      <= 1'b0;
      step_ready_q <= 1'b1;
      step_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      drain_q      <= drain_d;
      step_ready_q <= (state_d == IDLE);
      step_done_q  <= done_d;
    end
  end

  // Step operands are frozen at accept so the source may change mid-sweep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dt_q  <= '0;
      cur_q <= '0;
    end else if (accept_c) begin
      dt_q  <= bus.dt_k;
      cur_q <= bus.current_in;
    end
  end

  // Operand read for the channel being issued.
  always_comb begin
    rd_v_c    = v_mem[cnt_q];
    rd_refr_c = refr_mem[cnt_q];
    rd_i_c    = cur_q[32'(cnt_q) * W +: W];
  end

  hh_update_dp #(
    .W       (W),
    .FRAC    (FRAC),
    .CH_W    (CH_W),
    .RW      (RW),
    .V_TH    (V_TH),
    .V_RESET (V_RESET),
    .E_NA    (E_NA),
    .E_K     (E_K),
    .E_L     (E_L),
    .G_NA    (G_NA),
    .G_K     (G_K),
    .G_L     (G_L),
    .REFRACT (REFRACT)
  ) u_dp (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (issue_c),
    .in_ch     (cnt_q),
    .in_v      (rd_v_c),
    .in_refr   (rd_refr_c),
    .in_i      (rd_i_c),
    .in_dt     (dt_q),
    .out_valid (wb_valid),
    .out_ch    (wb_ch),
    .out_v     (wb_v),
    .out_refr  (wb_refr),
    .out_spike (wb_spike)
  );

  // Per-channel state; the presented result is what gets written back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        v_mem[i]    <= VREST_W;
        refr_mem[i] <= '0;
      end
    end else if (wb_valid) begin
      v_mem[wb_ch]    <= wb_v;
      refr_mem[wb_ch] <= wb_refr;
    end
  end

  assign bus.step_ready = step_ready_q;
  assign bus.step_done  = step_done_q;
  assign bus.out_valid  = wb_valid;
  assign bus.out_ch     = wb_ch;
  assign bus.out_v      = wb_v;
  assign bus.out_spike  = wb_spike;

endmodule

// File: tb/tb_hh_neuron_array.sv
// Bench for hh_neuron_array: three instances (default conductances, zero
// conductances, zero conductances with V_TH at full scale) share one
// stimulus stream and are each compared with a plain-arithmetic model.
module tb_hh_neuron_array;
  import hh_pkg::*;

  localparam int unsigned W      = 16;
  localparam int unsigned NUM_CH = 4;
  localparam int          NI     = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                step_valid;
  logic signed [W-1:0] dt_k;
  logic [NUM_CH*W-1:0] current_in;

  hh_neuron_array_if #(.W(W), .NUM_CH(NUM_CH)) if_a ();
  hh_neuron_array_if #(.W(W), .NUM_CH(NUM_CH)) if_b ();
  hh_neuron_array_if #(.W(W), .NUM_CH(NUM_CH)) if_c ();

  assign if_a.step_valid = step_valid;
  assign if_a.dt_k       = dt_k;
  assign if_a.current_in = current_in;
  assign if_b.step_valid = step_valid;
  assign if_b.dt_k       = dt_k;
  assign if_b.current_in = current_in;
  assign if_c.step_valid = step_valid;
  assign if_c.dt_k       = dt_k;
  assign if_c.current_in = current_in;

  hh_neuron_array #(.W(W), .NUM_CH(NUM_CH)) dut_a (
    .clk(clk), .rst(rst), .bus(if_a.slave)
  );
  hh_neuron_array #(.W(W), .NUM_CH(NUM_CH), .G_NA(0), .G_K(0), .G_L(0)) dut_b (
    .clk(clk), .rst(rst), .bus(if_b.slave)
  );
  hh_neuron_array #(.W(W), .NUM_CH(NUM_CH), .G_NA(0), .G_K(0), .G_L(0), .V_TH(32767)) dut_c (
    .clk(clk), .rst(rst), .bus(if_c.slave)
  );

  logic                o_valid [NI];
  logic                o_ready [NI];
  logic                o_done  [NI];
  logic                o_spike [NI];
  logic [1:0]          o_ch    [NI];
  logic signed [W-1:0] o_v     [NI];

  assign o_valid[0] = if_a.out_valid;  assign o_valid[1] = if_b.out_valid;  assign o_valid[2] = if_c.out_valid;
  assign o_ready[0] = if_a.step_ready; assign o_ready[1] = if_b.step_ready; assign o_ready[2] = if_c.step_ready;
  assign o_done[0]  = if_a.step_done;  assign o_done[1]  = if_b.step_done;  assign o_done[2]  = if_c.step_done;
  assign o_spike[0] = if_a.out_spike;  assign o_spike[1] = if_b.out_spike;  assign o_spike[2] = if_c.out_spike;
  assign o_ch[0]    = if_a.out_ch;     assign o_ch[1]    = if_b.out_ch;     assign o_ch[2]    = if_c.out_ch;
  assign o_v[0]     = if_a.out_v;      assign o_v[1]     = if_b.out_v;      assign o_v[2]     = if_c.out_v;

  // Model configuration per instance.
  int g_na [NI] = '{8, 0, 0};
  int g_k  [NI] = '{9, 0, 0};
  int g_l  [NI] = '{1, 0, 0};
  int v_th [NI] = '{-14080, -14080, 32767};

  longint mv [NI][NUM_CH];
  int     mr [NI][NUM_CH];
  longint ev [NI][NUM_CH];
  bit     es [NI][NUM_CH];

  int vectors     = 0;
  int miscompares = 0;

  function automatic longint fdiv(input longint x, input longint d);
    longint q;
    q = x / d;
    if ((x % d != 0) && (x < 0)) q = q - 1;
    return q;
  endfunction

  function automatic longint qmul(input longint a, input longint b);
    return fdiv(a * b, 256);
  endfunction

  function automatic longint clamp(input longint x);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  task automatic model_reset();
    for (int n = 0; n < NI; n++)
      for (int c = 0; c < int'(NUM_CH); c++) begin
        mv[n][c] = HH_V_REST;
        mr[n][c] = 0;
      end
  endtask

  task automatic model_step(input int n, input int ch, input longint i_in, input longint dt,
                            output longint v_exp, output bit sp_exp);
    longint v, ion, vp;
    v = mv[n][ch];
    sp_exp = 1'b0;
    if (mr[n][ch] > 0) begin
      mr[n][ch] = mr[n][ch] - 1;
      mv[n][ch] = HH_V_RESET;
    end else begin
      ion = qmul(g_na[n], v - HH_E_NA) + qmul(g_k[n], v - HH_E_K) + qmul(g_l[n], v - HH_E_L);
      vp  = clamp(v + qmul(dt, clamp(i_in - ion)));
      if (vp >= v_th[n]) begin
        mv[n][ch] = HH_V_RESET;
        mr[n][ch] = 2;
        sp_exp    = 1'b1;
      end else begin
        mv[n][ch] = vp;
      end
    end
    v_exp = mv[n][ch];
  endtask

  function automatic logic [63:0] pack4(input int c0, input int c1, input int c2, input int c3);
    return {16'(c3), 16'(c2), 16'(c1), 16'(c0)};
  endfunction

  function automatic int rand_cur();
    if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 65535)) - 32768;
    return int'($urandom_range(0, 4096)) - 2048;
  endfunction

  // Reset-state checks shared by the reset scenarios, sampled while rst is high.
  task automatic check_reset_outputs(input string tag);
    for (int n = 0; n < NI; n++) begin
      vectors++;
      if (o_valid[n] !== 1'b0 || o_spike[n] !== 1'b0 || o_done[n] !== 1'b0) begin
        miscompares++;
        $display("FAIL %s inst%0d flags: got valid=%b spike=%b done=%b, want 0/0/0",
                 tag, n, o_valid[n], o_spike[n], o_done[n]);
      end
      vectors++;
      if (o_ch[n] !== 2'd0 || o_v[n] !== 16'sd0) begin
        miscompares++;
        $display("FAIL %s inst%0d data: got ch=%0d v=%0d, want 0/0", tag, n, o_ch[n], o_v[n]);
      end
      vectors++;
      if (o_ready[n] !== 1'b1) begin
        miscompares++;
        $display("FAIL %s inst%0d step_ready: got %b, want 1", tag, n, o_ready[n]);
      end
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    step_valid = 1'b0;
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // One full step starting at a negedge; ends at the negedge of the done cycle.
  task automatic do_step(input logic signed [W-1:0] dt, input logic [NUM_CH*W-1:0] cur, input bit hold);
    logic signed [W-1:0] s;
    bit exp_valid;
    int ch;
    for (int n = 0; n < NI; n++) begin
      vectors++;
      if (o_ready[n] !== 1'b1) begin
        miscompares++;
        $display("FAIL ready_before_step inst%0d: got %b, want 1", n, o_ready[n]);
      end
    end
    step_valid = 1'b1;
    dt_k       = dt;
    current_in = cur;
    for (int n = 0; n < NI; n++)
      for (int c = 0; c < int'(NUM_CH); c++) begin
        s = cur[c*16 +: 16];
        model_step(n, c, longint'(s), longint'(dt), ev[n][c], es[n][c]);
      end
    @(posedge clk);
    for (int c = 0; c <= int'(NUM_CH) + 2; c++) begin
      @(negedge clk);
      exp_valid = (c >= 2) && (c <= int'(NUM_CH) + 1);
      ch = c - 2;
      for (int n = 0; n < NI; n++) begin
        vectors++;
        if (o_valid[n] !== exp_valid) begin
          miscompares++;
          $display("FAIL out_valid inst%0d cyc%0d: got %b, want %b", n, c, o_valid[n], exp_valid);
        end
        if (exp_valid) begin
          vectors++;
          if (o_ch[n] !== 2'(ch)) begin
            miscompares++;
            $display("FAIL out_ch inst%0d cyc%0d: got %0d, want %0d", n, c, o_ch[n], ch);
          end
          vectors++;
          if (o_v[n] !== 16'(ev[n][ch])) begin
            miscompares++;
            $display("FAIL out_v inst%0d ch%0d: got %0d, want %0d", n, ch, o_v[n], ev[n][ch]);
          end
          vectors++;
          if (o_spike[n] !== es[n][ch]) begin
            miscompares++;
            $display("FAIL out_spike inst%0d ch%0d: got %b, want %b", n, ch, o_spike[n], es[n][ch]);
          end
        end
        vectors++;
        if (o_done[n] !== (c == int'(NUM_CH) + 2)) begin
          miscompares++;
          $display("FAIL step_done inst%0d cyc%0d: got %b, want %b", n, c, o_done[n], c == int'(NUM_CH) + 2);
        end
        vectors++;
        if (o_ready[n] !== (c == int'(NUM_CH) + 2)) begin
          miscompares++;
          $display("FAIL step_ready inst%0d cyc%0d: got %b, want %b", n, c, o_ready[n], c == int'(NUM_CH) + 2);
        end
      end
      if (hold && c < int'(NUM_CH) + 2) begin
        step_valid = 1'b1;
        dt_k       = 16'($urandom);
        current_in = {$urandom(), $urandom()};
      end else begin
        step_valid = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_timing();
    apply_reset();
    do_step(16'sd0, pack4(0, 0, 0, 0), 1'b1);
    do_step(16'sd0, pack4(rand_cur(), rand_cur(), rand_cur(), rand_cur()), 1'b1);
  endtask

  task automatic test_reset_mid_sweep();
    step_valid = 1'b1;
    dt_k       = 16'sd256;
    current_in = pack4(3000, 3000, 3000, 3000);
    @(posedge clk);
    @(negedge clk);
    step_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outputs("midsweep_reset");
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 2) rst = 1'b0;
      for (int n = 0; n < NI; n++) begin
        vectors++;
        if (o_done[n] !== 1'b0 || o_valid[n] !== 1'b0) begin
          miscompares++;
          $display("FAIL aborted_sweep inst%0d k%0d: got done=%b valid=%b, want 0/0",
                   n, k, o_done[n], o_valid[n]);
        end
      end
    end
    model_reset();
    do_step(16'sd0, pack4(rand_cur(), rand_cur(), rand_cur(), rand_cur()), 1'b0);
  endtask

  task automatic test_arith();
    apply_reset();
    do_step(16'sd256, pack4(0, 512, 0, 0), 1'b0);
    do_step(16'sd256, pack4(0, 512, 0, 0), 1'b0);
  endtask

  task automatic test_spike_refractory();
    apply_reset();
    for (int k = 0; k < 5; k++) do_step(16'sd256, pack4(3072, 0, 0, 0), 1'b0);
  endtask

  task automatic test_saturation();
    apply_reset();
    do_step(16'sd32767, pack4(rand_cur(), rand_cur(), -32768, 32767), 1'b0);
    do_step(-16'sd32768, pack4(32767, -32768, -32768, 32767), 1'b1);
  endtask

  task automatic test_drift();
    apply_reset();
    for (int k = 0; k < 20; k++) do_step(16'sd256, pack4(0, 0, 0, 0), 1'b0);
  endtask

  task automatic test_random();
    logic signed [W-1:0] dt;
    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(0, 1) == 1) dt = 16'($urandom_range(0, 600));
      else dt = 16'($urandom);
      do_step(dt, pack4(rand_cur(), rand_cur(), rand_cur(), rand_cur()), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    step_valid = 1'b0;
    dt_k       = '0;
    current_in = '0;
    model_reset();
    test_reset();
    test_timing();
    test_reset_mid_sweep();
    test_arith();
    test_spike_refractory();
    test_saturation();
    test_drift();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
